// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, reset values, decode and byte-merge helpers.
package clint_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [ADDR_W-1:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [ADDR_W-1:0] CLINT_MTIME_OFF    = 16'hBFF8;

    // All-ones compare value keeps mtip low out of reset.
    localparam logic [DATA_W-1:0] MTIMECMP_RST = '1;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } clint_reg_e;

    typedef enum logic {
        ST_IDLE,
        ST_ACK
    } clint_state_e;

    function automatic clint_reg_e clint_decode(input logic [ADDR_W-1:0] addr);
        case (addr)
            CLINT_MSIP_OFF:     return REG_MSIP;
            CLINT_MTIMECMP_OFF: return REG_MTIMECMP;
            CLINT_MTIME_OFF:    return REG_MTIME;
            default:            return REG_NONE;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] clint_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [MASK_W-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < MASK_W; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_if.sv
// MEM-stage access port of the CLINT plus the interrupt lines toward mem_csr.
interface clint_if;
    import clint_pkg::*;

    logic              clint_req_i;
    logic              clint_we_i;
    logic [ADDR_W-1:0] clint_addr_i;
    logic [DATA_W-1:0] clint_wdata_i;
    logic [MASK_W-1:0] clint_wmask_i;
    logic              clint_ack_o;
    logic [DATA_W-1:0] clint_rdata_o;
    logic              clint_mtip_o;
    logic              clint_update_o;
    logic              clint_msip_o;

    modport master (
        output clint_req_i, clint_we_i, clint_addr_i, clint_wdata_i, clint_wmask_i,
        input  clint_ack_o, clint_rdata_o, clint_mtip_o, clint_update_o, clint_msip_o
    );

    modport slave (
        input  clint_req_i, clint_we_i, clint_addr_i, clint_wdata_i, clint_wmask_i,
        output clint_ack_o, clint_rdata_o, clint_mtip_o, clint_update_o, clint_msip_o
    );

endinterface

// File: rtl/clint_prescaler.sv
// mtime prescaler: down-counter reloaded with TICK_DIV-1, tick on terminal count 0.
module clint_prescaler #(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Remaining cycles to the next tick; clear restarts a full TICK_DIV period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= TC_LOAD;
        end else if (i_clr || (r_cnt == '0)) begin
            r_cnt <= TC_LOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/clint.sv
// Core-local interruptor: msip, mtime, mtimecmp on the MEM load/store path; drives mtip/update/msip.
//   state   | meaning
//   ST_IDLE | no access in flight, req is sampled
//   ST_ACK  | ack/rdata presented for one cycle, req ignored
module clint
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int CNT_W    = 16
) (
    input  logic    clk,
    input  logic    rst,
    clint_if.slave  bus
);

    clint_state_e      r_state;
    clint_state_e      w_state_next;
    logic              w_accept;

    logic [DATA_W-1:0] r_mtime;
    logic [DATA_W-1:0] r_mtimecmp;
    logic              r_msip;
    logic              r_mtip;
    logic              r_update;
    logic [DATA_W-1:0] r_rdata;

    clint_reg_e        w_region;
    logic              w_wr;
    logic              w_mtime_wr;
    logic              w_mtimecmp_wr;
    logic              w_msip_wr;
    logic              w_tick;
    logic [DATA_W-1:0] w_mtime_next;
    logic [DATA_W-1:0] w_mtimecmp_next;
    logic              w_msip_next;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.clint_req_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_region      = clint_decode(bus.clint_addr_i);
    assign w_wr          = w_accept && bus.clint_we_i && (bus.clint_wmask_i != '0);
    assign w_mtime_wr    = w_wr && (w_region == REG_MTIME);
    assign w_mtimecmp_wr = w_wr && (w_region == REG_MTIMECMP);
    assign w_msip_wr     = w_wr && (w_region == REG_MSIP) && bus.clint_wmask_i[0];

    clint_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_mtime_wr),
        .o_tick (w_tick)
    );

    // A software write to mtime overrides a coincident tick.
    always_comb begin
        w_mtime_next = r_mtime;
        if (w_mtime_wr) begin
            w_mtime_next = clint_merge(r_mtime, bus.clint_wdata_i, bus.clint_wmask_i);
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    assign w_mtimecmp_next = w_mtimecmp_wr
                           ? clint_merge(r_mtimecmp, bus.clint_wdata_i, bus.clint_wmask_i)
                           : r_mtimecmp;
    assign w_msip_next     = w_msip_wr ? bus.clint_wdata_i[0] : r_msip;

    always_comb begin
        w_rdata = '0;
        case (w_region)
            REG_MSIP:     w_rdata = {{(DATA_W-1){1'b0}}, r_msip};
            REG_MTIMECMP: w_rdata = r_mtimecmp;
            REG_MTIME:    w_rdata = r_mtime;
            default:      w_rdata = '0;
        endcase
    end

    // mtip compares next-state values so it tracks writes and ticks with one register of delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RST;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_update   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            r_msip     <= w_msip_next;
            r_mtip     <= (w_mtime_next >= w_mtimecmp_next);
            r_update   <= w_mtime_wr || w_mtimecmp_wr;
            r_rdata    <= (w_accept && !bus.clint_we_i) ? w_rdata : '0;
        end
    end

    assign bus.clint_ack_o    = (r_state == ST_ACK);
    assign bus.clint_rdata_o  = r_rdata;
    assign bus.clint_mtip_o   = r_mtip;
    assign bus.clint_update_o = r_update;
    assign bus.clint_msip_o   = r_msip;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: vector table, directed corner sequences and random accesses.
module tb_clint;

    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    clint_if bus();

    clint #(.TICK_DIV(TICK_DIV), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Number of rising edges since reset release.
    int ec;
    always @(posedge clk or negedge rst) begin
        if (!rst) ec <= 0;
        else      ec <= ec + 1;
    end

    // Reference model: mtime is an anchor value plus whole TICK_DIV periods elapsed since the anchor edge.
    logic [63:0] m_anchor_val;
    int          m_anchor_e;
    logic [63:0] m_cmp;
    logic        m_msip;
    int          ack_edge;
    int          upd_edge;
    bit          mon_on;
    logic [63:0] rd;

    function automatic logic [63:0] m_mtime(input int e);
        return m_anchor_val + 64'((e - m_anchor_e) / TICK_DIV);
    endfunction

    function automatic logic [63:0] m_merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_anchor_val = 64'd0;
        m_anchor_e   = 0;
        m_cmp        = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip       = 1'b0;
        ack_edge     = -1;
        upd_edge     = -1;
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && rst) begin
            check64("mtip",   64'(bus.clint_mtip_o),   64'(m_mtime(ec) >= m_cmp));
            check64("update", 64'(bus.clint_update_o), 64'(ec == upd_edge));
            check64("ack",    64'(bus.clint_ack_o),    64'(ec == ack_edge));
            check64("msip",   64'(bus.clint_msip_o),   64'(m_msip));
            if (ec != ack_edge) check64("rdata_idle", bus.clint_rdata_o, 64'd0);
        end
    end

    task automatic access(input logic we, input logic [15:0] addr, input logic [63:0] wdata,
                          input logic [7:0] mask, output logic [63:0] rdata);
        int          exp_acc;
        int          e_acc;
        bit          got;
        logic [63:0] mt_pre;
        logic [63:0] exp_rd;
        @(negedge clk);
        exp_acc = ec + ((ec == ack_edge) ? 2 : 1);
        bus.clint_req_i   = 1'b1;
        bus.clint_we_i    = we;
        bus.clint_addr_i  = addr;
        bus.clint_wdata_i = wdata;
        bus.clint_wmask_i = mask;
        got   = 0;
        e_acc = -1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.clint_ack_o) begin
                got   = 1;
                e_acc = ec;
            end
        end
        bus.clint_req_i = 1'b0;
        total++;
        if (!got || e_acc != exp_acc) begin
            bad++;
            $display("FAIL ack_latency: ack at edge %0d expected edge %0d", e_acc, exp_acc);
        end
        mt_pre = m_mtime(exp_acc - 1);
        exp_rd = 64'd0;
        if (!we) begin
            case (addr)
                16'h0000: exp_rd = {63'd0, m_msip};
                16'h4000: exp_rd = m_cmp;
                16'hBFF8: exp_rd = mt_pre;
                default:  exp_rd = 64'd0;
            endcase
        end
        rdata = bus.clint_rdata_o;
        check64("rdata", rdata, exp_rd);
        ack_edge = exp_acc;
        if (we && mask != 8'h00) begin
            case (addr)
                16'h0000: if (mask[0]) m_msip = wdata[0];
                16'h4000: begin
                    m_cmp    = m_merge(m_cmp, wdata, mask);
                    upd_edge = exp_acc;
                end
                16'hBFF8: begin
                    m_anchor_val = m_merge(mt_pre, wdata, mask);
                    m_anchor_e   = exp_acc;
                    upd_edge     = exp_acc;
                end
                default: ;
            endcase
        end
    endtask

    task automatic wait_mtip(input logic lvl, input int budget, input string name);
        int n = 0;
        while (bus.clint_mtip_o !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.clint_mtip_o !== lvl) begin
            bad++;
            $display("FAIL %s: mtip=%b never reached %b within %0d cycles", name, bus.clint_mtip_o, lvl, budget);
        end
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{1'b1, 16'h0000, 64'd3,                     8'hFF, 64'd0};
        vecs[1]  = '{1'b0, 16'h0000, 64'd0,                     8'h00, 64'd1};
        vecs[2]  = '{1'b1, 16'h0000, 64'd0,                     8'h00, 64'd0};
        vecs[3]  = '{1'b0, 16'h0000, 64'd0,                     8'h00, 64'd1};
        vecs[4]  = '{1'b1, 16'h0000, 64'd0,                     8'h01, 64'd0};
        vecs[5]  = '{1'b0, 16'h0000, 64'd0,                     8'h00, 64'd0};
        vecs[6]  = '{1'b1, 16'h2000, 64'hFFFF_FFFF_FFFF_FFFF,   8'hFF, 64'd0};
        vecs[7]  = '{1'b0, 16'h2000, 64'd0,                     8'h00, 64'd0};
        vecs[8]  = '{1'b1, 16'h4000, 64'h1234_5678_9ABC_DEF0,   8'hFF, 64'd0};
        vecs[9]  = '{1'b0, 16'h4000, 64'd0,                     8'h00, 64'h1234_5678_9ABC_DEF0};
        vecs[10] = '{1'b1, 16'h4000, 64'd0,                     8'h0F, 64'd0};
        vecs[11] = '{1'b0, 16'h4000, 64'd0,                     8'h00, 64'h1234_5678_0000_0000};
        vecs[12] = '{1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF,   8'hFF, 64'd0};
        vecs[13] = '{1'b0, 16'h4000, 64'd0,                     8'h00, 64'hFFFF_FFFF_FFFF_FFFF};

        bus.clint_req_i   = 1'b0;
        bus.clint_we_i    = 1'b0;
        bus.clint_addr_i  = 16'h0;
        bus.clint_wdata_i = 64'h0;
        bus.clint_wmask_i = 8'h0;
        mon_on = 0;
        model_reset();

        #12;
        check64("rst_ack",    64'(bus.clint_ack_o),    64'd0);
        check64("rst_rdata",  bus.clint_rdata_o,       64'd0);
        check64("rst_mtip",   64'(bus.clint_mtip_o),   64'd0);
        check64("rst_update", 64'(bus.clint_update_o), 64'd0);
        check64("rst_msip",   64'(bus.clint_msip_o),   64'd0);

        @(negedge clk);
        rst    = 1'b1;
        mon_on = 1;

        // 40 clocks at TICK_DIV=4 from reset release
        while (ec < 40) @(negedge clk);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
        check64("mtime_after_40", rd, 64'd10);

        // mtimecmp=5 with mtime=2, wait for mtip
        access(1'b1, 16'hBFF8, 64'd2, 8'hFF, rd);
        access(1'b1, 16'h4000, 64'd5, 8'hFF, rd);
        check64("cmp5_update", 64'(bus.clint_update_o), 64'd1);
        wait_mtip(1'b1, 40, "mtip_at_cmp5");
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd);

        // raise mtimecmp above mtime: mtip clears with update
        access(1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd);
        check64("raise_cmp_mtip",   64'(bus.clint_mtip_o),   64'd0);
        check64("raise_cmp_update", 64'(bus.clint_update_o), 64'd1);

        // wrap of mtime through 2**64-1
        access(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd);
        wait_mtip(1'b1, 20, "mtip_at_max");
        wait_mtip(1'b0, 20, "mtip_after_wrap");
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd);

        // mtime write landing on a tick edge
        repeat (2) @(negedge clk);
        do @(negedge clk); while (((ec + 2 - m_anchor_e) % TICK_DIV) != 0);
        access(1'b1, 16'hBFF8, 64'h100, 8'hFF, rd);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
        check64("mtime_write_on_tick", rd, 64'h100);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd);
        check64("mtime_restart_incr", rd, 64'h101);

        for (int i = 0; i < 14; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, rd);
            check64($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end

        // reset in the middle of an access
        access(1'b1, 16'h0000, 64'd3, 8'hFF, rd);
        access(1'b1, 16'h4000, 64'h55, 8'hFF, rd);
        @(negedge clk);
        bus.clint_req_i  = 1'b1;
        bus.clint_we_i   = 1'b0;
        bus.clint_addr_i = 16'h4000;
        mon_on = 0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check64("midrst_ack",    64'(bus.clint_ack_o),    64'd0);
        check64("midrst_rdata",  bus.clint_rdata_o,       64'd0);
        check64("midrst_mtip",   64'(bus.clint_mtip_o),   64'd0);
        check64("midrst_update", 64'(bus.clint_update_o), 64'd0);
        check64("midrst_msip",   64'(bus.clint_msip_o),   64'd0);
        bus.clint_req_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst    = 1'b1;
        mon_on = 1;
        access(1'b0, 16'h0000, 64'd0, 8'h00, rd);
        check64("postrst_msip", rd, 64'd0);
        access(1'b0, 16'h4000, 64'd0, 8'h00, rd);
        check64("postrst_cmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        access(1'b0, 16'hBFF8, 64'd0, 8'h00, rd);

        // random traffic against the model
        for (int i = 0; i < 120; i++) begin
            logic        we;
            logic [15:0] addr;
            logic [63:0] wd;
            logic [7:0]  mk;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            case ($urandom_range(0, 3))
                0:       addr = 16'h0000;
                1:       addr = 16'h4000;
                2:       addr = 16'hBFF8;
                default: addr = 16'($urandom_range(0, 8191)) << 3;
            endcase
            we = 1'($urandom_range(0, 1));
            mk = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) wd = {$urandom, $urandom};
            else                            wd = m_mtime(ec) + 64'($urandom_range(0, 12));
            access(we, addr, wd, mk, rd);
        end

        repeat (8) @(negedge clk);
        mon_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
